// File: rtl/dmux_stream_pkg.sv
// Shared definitions for the dmux_stream block: FSM encodings and drop-counter helpers.
package dmux_stream_pkg;

  localparam logic [0:0] DMUX_IDLE   = 1'b0;
  localparam logic [0:0] DMUX_LOCKED = 1'b1;

  localparam int DROP_CNT_W = 8;

  // Saturating increment; the counter parks at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (v == {DROP_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + DROP_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/dmux_stream_slot.sv
// One-entry output register for a single channel: a load wins over a pop, so a
// simultaneous pop and load keeps the slot full with no bubble.
module dmux_stream_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Data/valid register with load-over-pop priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/dmux_stream.sv
// Registered valid/ready demultiplexer routing one input stream to NCHAN
// one-entry channel slots, with optional per-packet routing lock.
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NCHAN = 4,
  localparam int SELW  = $clog2(NCHAN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SELW-1:0]        in_sel,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   lock_en,
  output logic                   in_ready,
  output logic [NCHAN*WIDTH-1:0] out_data,
  output logic [NCHAN-1:0]       out_valid,
  input  logic [NCHAN-1:0]       out_ready,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int NSLOT = 1 << SELW;

  logic [0:0]            r_state;
  logic [SELW-1:0]       r_lock_sel;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [SELW-1:0]  w_target;
  logic [NSLOT-1:0] w_tgt_ready;
  logic [NSLOT-1:0] w_tgt_oob;
  logic [NCHAN-1:0] w_load;
  logic             w_accept;
  logic             w_drop;

  // Target channel: frozen to the latched select while a packet is locked.
  always_comb begin
    w_target = in_sel;
    if (r_state == DMUX_LOCKED) begin
      w_target = r_lock_sel;
    end else begin
      w_target = in_sel;
    end
  end

  // Select codes past the last channel always accept and are discarded.
  for (genvar k = 0; k < NSLOT; k++) begin : g_tgt
    if (k < NCHAN) begin : g_real
      assign w_tgt_ready[k] = !out_valid[k] || out_ready[k];
      assign w_tgt_oob[k]   = 1'b0;
    end else begin : g_oob
      assign w_tgt_ready[k] = 1'b1;
      assign w_tgt_oob[k]   = 1'b1;
    end
  end

  assign in_ready = w_tgt_ready[w_target];
  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && w_tgt_oob[w_target];

  for (genvar k = 0; k < NCHAN; k++) begin : g_slot
    assign w_load[k] = w_accept && (w_target == SELW'(k));

    dmux_stream_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_data  (out_data[k*WIDTH +: WIDTH]),
      .o_valid (out_valid[k])
    );
  end

  // Packet lock FSM; a single-beat packet never leaves IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= DMUX_IDLE;
      r_lock_sel <= {SELW{1'b0}};
    end else begin
      case (r_state)
        DMUX_IDLE: begin
          if (w_accept && lock_en && !in_last) begin
            r_state    <= DMUX_LOCKED;
            r_lock_sel <= in_sel;
          end
        end
        DMUX_LOCKED: begin
          if (w_accept && in_last) begin
            r_state <= DMUX_IDLE;
          end
        end
        default: begin
          r_state <= DMUX_IDLE;
        end
      endcase
    end
  end

  // Saturating count of discarded beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= {DROP_CNT_W{1'b0}};
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: a 4-channel instance driven from a vector
// table plus hand sequences, and a 3-channel instance for discarded beats.
module tb_dmux_stream;

  logic clk;
  logic reset;

  logic [15:0] d4_in_data;
  logic [1:0]  d4_in_sel;
  logic        d4_in_valid, d4_in_last, d4_lock_en, d4_in_ready;
  logic [63:0] d4_out_data;
  logic [3:0]  d4_out_valid, d4_out_ready;
  logic [7:0]  d4_drop;

  logic [7:0]  d3_in_data;
  logic [1:0]  d3_in_sel;
  logic        d3_in_valid, d3_in_last, d3_lock_en, d3_in_ready;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid, d3_out_ready;
  logic [7:0]  d3_drop;

  int n_checks;
  int n_fail;

  dmux_stream #(.WIDTH(16), .NCHAN(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_data(d4_in_data), .in_sel(d4_in_sel),
    .in_valid(d4_in_valid), .in_last(d4_in_last), .lock_en(d4_lock_en),
    .in_ready(d4_in_ready), .out_data(d4_out_data), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .drop_count(d4_drop)
  );

  dmux_stream #(.WIDTH(8), .NCHAN(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(d3_in_data), .in_sel(d3_in_sel),
    .in_valid(d3_in_valid), .in_last(d3_in_last), .lock_en(d3_lock_en),
    .in_ready(d3_in_ready), .out_data(d3_out_data), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .drop_count(d3_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        v;
    logic        l;
    logic        lk;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  ov;
    logic        chk;
    logic [1:0]  ch;
    logic [15:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] sel, input logic [15:0] data,
                              input logic v, input logic l, input logic lk,
                              input logic [3:0] ordy, input logic rdy,
                              input logic [3:0] ov, input logic chk,
                              input logic [1:0] ch, input logic [15:0] ed);
    vec_t r;
    r.sel = sel; r.data = data; r.v = v; r.l = l; r.lk = lk; r.ordy = ordy;
    r.rdy = rdy; r.ov = ov; r.chk = chk; r.ch = ch; r.ed = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  vec_t tbl[29];
  int   bad_rdy;
  int   bad_ov;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Each row: inputs for this cycle, then the in_ready they must see and
    // the out_valid/out_data left by earlier rows.
    tbl[0]  = mk(2'd2, 16'hA5A5, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[1]  = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hA5A5);
    tbl[2]  = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, 16'hA5A5);
    tbl[3]  = mk(2'd0, 16'h0001, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[4]  = mk(2'd1, 16'h0002, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0001);
    tbl[5]  = mk(2'd2, 16'h0003, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0002);
    tbl[6]  = mk(2'd3, 16'h0004, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h0003);
    tbl[7]  = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h0004);
    tbl[8]  = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[9]  = mk(2'd1, 16'h0011, 1'b1, 1'b1, 1'b0, 4'b1101, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[10] = mk(2'd1, 16'h0012, 1'b1, 1'b1, 1'b0, 4'b1101, 1'b0, 4'b0010, 1'b1, 2'd1, 16'h0011);
    tbl[11] = mk(2'd3, 16'h0033, 1'b1, 1'b1, 1'b0, 4'b1101, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0011);
    tbl[12] = mk(2'd1, 16'h0012, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b1010, 1'b1, 2'd3, 16'h0033);
    tbl[13] = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0012);
    tbl[14] = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[15] = mk(2'd1, 16'h0101, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[16] = mk(2'd3, 16'h0102, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0101);
    tbl[17] = mk(2'd3, 16'h0103, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0102);
    tbl[18] = mk(2'd3, 16'h0104, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0103);
    tbl[19] = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h0104);
    tbl[20] = mk(2'd2, 16'h0201, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[21] = mk(2'd0, 16'h0202, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h0201);
    tbl[22] = mk(2'd0, 16'h0202, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h0201);
    tbl[23] = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h0202);
    tbl[24] = mk(2'd0, 16'h0301, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[25] = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h0301);
    tbl[26] = mk(2'd1, 16'h0401, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    tbl[27] = mk(2'd2, 16'h0402, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h0401);
    tbl[28] = mk(2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h0402);

    reset = 1'b1;
    d4_in_data = 16'h0000; d4_in_sel = 2'd0; d4_in_valid = 1'b0;
    d4_in_last = 1'b0; d4_lock_en = 1'b0; d4_out_ready = 4'b1111;
    d3_in_data = 8'h00; d3_in_sel = 2'd0; d3_in_valid = 1'b0;
    d3_in_last = 1'b0; d3_lock_en = 1'b0; d3_out_ready = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_out_valid", 32'(d4_out_valid), 32'h0);
    check("reset_out_data", d4_out_data[31:0] | d4_out_data[63:32], 32'h0);
    check("reset_drop", 32'(d4_drop), 32'h0);
    check("reset_in_ready", 32'(d4_in_ready), 32'h1);

    for (int i = 0; i < 29; i++) begin
      d4_in_sel = tbl[i].sel; d4_in_data = tbl[i].data; d4_in_valid = tbl[i].v;
      d4_in_last = tbl[i].l; d4_lock_en = tbl[i].lk; d4_out_ready = tbl[i].ordy;
      #1;
      check($sformatf("row%0d_in_ready", i), 32'(d4_in_ready), 32'(tbl[i].rdy));
      check($sformatf("row%0d_out_valid", i), 32'(d4_out_valid), 32'(tbl[i].ov));
      if (tbl[i].chk) begin
        check($sformatf("row%0d_out_data_ch%0d", i, tbl[i].ch),
              32'(d4_out_data[tbl[i].ch*16 +: 16]), 32'(tbl[i].ed));
      end
      @(negedge clk);
    end
    check("dut4_drop_zero", 32'(d4_drop), 32'h0);

    // Reset in the middle of a locked packet with channel 0 holding a beat.
    d4_in_sel = 2'd0; d4_in_data = 16'h0A0A; d4_in_valid = 1'b1;
    d4_in_last = 1'b0; d4_lock_en = 1'b1; d4_out_ready = 4'b1110;
    @(negedge clk);
    d4_in_valid = 1'b0;
    #1;
    check("midrst_held", 32'(d4_out_valid), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(d4_out_valid), 32'h0);
    check("midrst_ch0_data", 32'(d4_out_data[15:0]), 32'h0);
    d4_in_sel = 2'd2; d4_in_data = 16'h0B0B; d4_in_valid = 1'b1;
    d4_in_last = 1'b1; d4_lock_en = 1'b0; d4_out_ready = 4'b1111;
    #1;
    check("midrst_in_ready", 32'(d4_in_ready), 32'h1);
    @(negedge clk);
    d4_in_valid = 1'b0;
    #1;
    check("midrst_route_valid", 32'(d4_out_valid), 32'h4);
    check("midrst_route_data", 32'(d4_out_data[47:32]), 32'h0B0B);

    // Three channels: select 3 has no slot, every beat is discarded.
    bad_rdy = 0;
    bad_ov  = 0;
    d3_in_sel = 2'd3; d3_in_valid = 1'b1; d3_in_last = 1'b1; d3_lock_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      d3_in_data = 8'(i);
      #1;
      if (d3_in_ready !== 1'b1) bad_rdy++;
      if (d3_out_valid !== 3'b000) bad_ov++;
      if (i == 10) check("drop_count_10", 32'(d3_drop), 32'd10);
      @(negedge clk);
    end
    #1;
    check("drop_in_ready_always", 32'(bad_rdy), 32'd0);
    check("drop_no_out_valid", 32'(bad_ov), 32'd0);
    check("drop_saturated", 32'(d3_drop), 32'd255);

    // Locked onto the missing channel: later beats drop despite in_sel = 0.
    d3_in_sel = 2'd3; d3_in_data = 8'h51; d3_in_last = 1'b0; d3_lock_en = 1'b1;
    @(negedge clk);
    d3_in_sel = 2'd0; d3_in_data = 8'h52; d3_in_last = 1'b0;
    #1;
    check("oob_lock_ready", 32'(d3_in_ready), 32'h1);
    @(negedge clk);
    d3_in_data = 8'h53; d3_in_last = 1'b1;
    #1;
    check("oob_lock_no_valid", 32'(d3_out_valid), 32'h0);
    @(negedge clk);
    d3_in_data = 8'h54; d3_in_last = 1'b1; d3_lock_en = 1'b0;
    #1;
    check("oob_lock_still_dropped", 32'(d3_out_valid), 32'h0);
    @(negedge clk);
    d3_in_valid = 1'b0;
    #1;
    check("oob_unlock_valid", 32'(d3_out_valid), 32'h1);
    check("oob_unlock_data", 32'(d3_out_data[7:0]), 32'h54);
    check("oob_drop_held", 32'(d3_drop), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
